// File: rtl/xps2_kbd_ctrl_pkg.sv
`default_nettype none
// =============================================================================
// xps2_kbd_ctrl_pkg : shared constants and types for the PS/2 keyboard receiver
// Rev 1.0
// =============================================================================
package xps2_kbd_ctrl_pkg;

  localparam int DATA_W = 32;

  localparam logic [7:0] PS2_BRK_CODE = 8'hF0;
  localparam logic [7:0] PS2_EXT_CODE = 8'hE0;

  localparam logic PS2_EVT_ADDR  = 1'b0;
  localparam logic PS2_STAT_ADDR = 1'b1;

  localparam int ST_OVF_BIT    = 0;
  localparam int ST_FRM_BIT    = 1;
  localparam int ST_TMO_BIT    = 2;
  localparam int ST_CNT_LSB    = 16;
  localparam int EVT_VALID_BIT = 10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } frame_state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_event_t;

  // Odd parity: the 8 data bits plus the parity bit hold an odd number of ones.
  function automatic logic parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage
`default_nettype wire

// File: rtl/xps2_kbd_ctrl_fifo.sv
`default_nettype none
// =============================================================================
// xps2_kbd_ctrl_fifo : single-clock event FIFO; push and pop may coincide when full
// Rev 1.0
// =============================================================================
module xps2_kbd_ctrl_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/xps2_kbd_ctrl.sv
`default_nettype none
// =============================================================================
// xps2_kbd_ctrl : PS/2 keyboard receiver, E0/F0 decode, event FIFO, 2-word port
// Option macro PS2_RELEASE_EN queues break events too.   Rev 1.0
// =============================================================================
module xps2_kbd_ctrl
  import xps2_kbd_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  input  logic              sel,
  input  logic              we,
  input  logic              addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              irq
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic [1:0]       clk_sync;
  logic [1:0]       data_sync;
  logic             clk_prev;
  logic             fall;
  logic             bit_in;
  frame_state_t     state, state_n;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  logic             par;
  logic [TMO_W-1:0] tmo_cnt;
  logic             frame_ok, frame_bad, tmo_hit;
  logic             byte_rdy;
  logic             ext, brk;
  logic             ovf, frame_err, timeout_err;
  logic             is_ext, is_brk;
  logic             push_req, pop_req, ovf_set;
  logic [2:0]       clr;
  logic             full, empty;
  logic [CNT_W-1:0] count;
  key_event_t       entry, head;
  logic             unused_data_in;

  // Lines idle high, so the synchroniser resets high to avoid a false first fall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      clk_prev  <= clk_sync[1];
    end
  end

  assign fall   = ~clk_sync[1] & clk_prev;
  assign bit_in = data_sync[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n   = state;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    tmo_hit   = 1'b0;
    if (fall) begin
      case (state)
        S_IDLE:   if (!bit_in) state_n = S_DATA;
        S_DATA:   if (bit_cnt == 3'd7) state_n = S_PARITY;
        S_PARITY: state_n = S_STOP;
        S_STOP: begin
          state_n = S_IDLE;
          if (bit_in && parity_ok(shift, par)) frame_ok  = 1'b1;
          else                                 frame_bad = 1'b1;
        end
        default:  state_n = S_IDLE;
      endcase
    end else if (state != S_IDLE && tmo_cnt == TMO_LAST) begin
      state_n = S_IDLE;
      tmo_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt  <= '0;
      shift    <= '0;
      par      <= 1'b0;
      tmo_cnt  <= '0;
      byte_rdy <= 1'b0;
    end else begin
      byte_rdy <= frame_ok;
      if (fall || state == S_IDLE) tmo_cnt <= '0;
      else                         tmo_cnt <= tmo_cnt + TMO_W'(1);
      if (fall) begin
        case (state)
          S_IDLE:   bit_cnt <= '0;
          S_DATA: begin
            shift   <= {bit_in, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          S_PARITY: par <= bit_in;
          default:  ;
        endcase
      end
    end
  end

  // shift holds the accepted byte during the decode cycle; the next fall is many clocks away.
  assign is_ext = (shift == PS2_EXT_CODE);
  assign is_brk = (shift == PS2_BRK_CODE);

`ifdef PS2_RELEASE_EN
  assign push_req = byte_rdy & ~is_ext & ~is_brk;
  assign entry    = {ext, brk, shift};
`else
  assign push_req = byte_rdy & ~is_ext & ~is_brk & ~brk;
  assign entry    = {ext, 1'b0, shift};
`endif

  assign pop_req = sel & ~we & (addr == PS2_EVT_ADDR);
  assign ovf_set = push_req & full & ~pop_req;
  assign clr     = (sel && we && addr == PS2_STAT_ADDR) ? data_in[2:0] : 3'b000;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext         <= 1'b0;
      brk         <= 1'b0;
      ovf         <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (byte_rdy) begin
        if (is_ext)      ext <= 1'b1;
        else if (is_brk) brk <= 1'b1;
        else begin
          ext <= 1'b0;
          brk <= 1'b0;
        end
      end
      ovf         <= ovf_set   | (ovf         & ~clr[ST_OVF_BIT]);
      frame_err   <= frame_bad | (frame_err   & ~clr[ST_FRM_BIT]);
      timeout_err <= tmo_hit   | (timeout_err & ~clr[ST_TMO_BIT]);
    end
  end

  xps2_kbd_ctrl_fifo #(
    .WIDTH ($bits(key_event_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (pop_req),
    .wdata (entry),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    data_out = '0;
    if (sel && !we) begin
      if (addr == PS2_EVT_ADDR) begin
        if (!empty) begin
          data_out[EVT_VALID_BIT] = 1'b1;
          data_out[9:0]           = head;
        end
      end else begin
        data_out[ST_CNT_LSB +: CNT_W] = count;
        data_out[ST_TMO_BIT]          = timeout_err;
        data_out[ST_FRM_BIT]          = frame_err;
        data_out[ST_OVF_BIT]          = ovf;
      end
    end
  end

  assign irq            = ~empty;
  assign unused_data_in = &{1'b0, data_in[DATA_W-1:3]};

endmodule
`default_nettype wire
